// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divider defaults, frame bit counts, the
// receiver state encoding and a parity helper.  Used by uart_rx and by the
// companion transmitter.
//
// Build option: UART_RX_PARITY_EN adds the PARITY receiver state (8E1 frames).
package uart_pkg;

    // 50 MHz clock, 115 200 Bd
    localparam int CLK_DIV_DEFAULT  = 434;
    localparam int HALF_DIV_DEFAULT = 217;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;
    localparam int CNT_W     = 10;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
        ,
        PARITY    = 3'd5
`endif
    } rx_state_t;

    // Even-parity bit for a data byte (1 when the byte has an odd number of ones)
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.  Both flops reset to 1
// so an idle-high serial line does not show a false edge coming out of reset.
//
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-high reset
//   d     - asynchronous input
//   q     - synchronized output (2 cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;
    logic stable;

    // Synchronizer chain
    always_ff @(posedge clk) begin
        if (reset) begin
            meta   <= 1'b1;
            stable <= 1'b1;
        end else begin
            meta   <= d;
            stable <= meta;
        end
    end

    assign q = stable;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
// The line is synchronized, a falling edge starts a frame, the start bit is
// re-checked at its middle and every following bit is sampled one bit period
// later, i.e. at its centre.
//
// Build option: UART_RX_PARITY_EN -- adds PARITY state and opParityError.
//
// Ports:
//   ipClk         - clock, rising edge
//   ipReset       - synchronous, active-high reset
//   ipRx          - asynchronous serial line, idle high
//   opRxData      - last correctly received byte, held until the next one
//   opRxValid     - one-cycle pulse, opRxData valid in the same cycle
//   opFrameError  - one-cycle pulse when the stop bit samples low
//   opParityError - (parity build) one-cycle pulse on a parity mismatch
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV  = CLK_DIV_DEFAULT,
    parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
    input  logic       ipClk,
    input  logic       ipReset,
    input  logic       ipRx,
    output logic [7:0] opRxData,
    output logic       opRxValid,
    output logic       opFrameError
`ifdef UART_RX_PARITY_EN
    ,
    output logic       opParityError
`endif
);

    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(HALF_DIV - 1);
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLK_DIV - 1);
    localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] clk_count;
    logic [2:0]       bit_index;
    logic [7:0]       shift;
    logic             rx_sync;
    logic             rx_prev;
    logic [1:0]       flush;
    logic             fall;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_error;

    // FSM action strobes
    logic cnt_clr;
    logic shift_en;
    logic set_valid;
    logic set_ferr;
`ifdef UART_RX_PARITY_EN
    logic par_chk;
    logic set_perr;
    logic par_bad;
    logic parity_error;
`endif

    sync_2ff u_sync (
        .clk   (ipClk),
        .reset (ipReset),
        .d     (ipRx),
        .q     (rx_sync)
    );

    // rx_prev is forced low until the synchronizer has flushed its reset
    // value, so a line that is already low when reset lifts never looks
    // like a fresh start edge.
    assign fall = rx_prev & ~rx_sync;

    // Edge-detect history and post-reset flush counter
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            rx_prev <= 1'b0;
            flush   <= 2'd0;
        end else begin
            if (flush == 2'd2) begin
                rx_prev <= rx_sync;
                flush   <= flush;
            end else begin
                rx_prev <= 1'b0;
                flush   <= flush + 2'd1;
            end
        end
    end

    // State register
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-cycle action strobes
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        shift_en   = 1'b0;
        set_valid  = 1'b0;
        set_ferr   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk    = 1'b0;
        set_perr   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_clr = 1'b1;
                if (fall) begin
                    state_next = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (clk_count == HALF_END) begin
                    cnt_clr = 1'b1;
                    // a start bit that is no longer low at its middle was a glitch
                    if (!rx_sync) begin
                        state_next = DATA;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = START;
                end
            end
            DATA: begin
                if (clk_count == BIT_END) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_index == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        state_next = DATA;
                    end
                end else begin
                    state_next = DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_count == BIT_END) begin
                    cnt_clr    = 1'b1;
                    par_chk    = 1'b1;
                    state_next = STOP;
                end else begin
                    state_next = PARITY;
                end
            end
`endif
            STOP: begin
                if (clk_count == BIT_END) begin
                    cnt_clr = 1'b1;
                    if (rx_sync) begin
                        state_next = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            set_perr = 1'b1;
                        end else begin
                            set_valid = 1'b1;
                        end
`else
                        set_valid = 1'b1;
`endif
                    end else begin
                        set_ferr   = 1'b1;
                        state_next = WAIT_IDLE;
                    end
                end else begin
                    state_next = STOP;
                end
            end
            WAIT_IDLE: begin
                cnt_clr = 1'b1;
                if (rx_sync) begin
                    state_next = IDLE;
                end else begin
                    state_next = WAIT_IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Bit-period counter, bit index and shift register
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            clk_count <= {CNT_W{1'b0}};
            bit_index <= 3'd0;
            shift     <= 8'h00;
        end else begin
            if (cnt_clr) begin
                clk_count <= {CNT_W{1'b0}};
            end else begin
                clk_count <= clk_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (state == IDLE) begin
                bit_index <= 3'd0;
            end else if (shift_en) begin
                bit_index <= bit_index + 3'd1;
            end else begin
                bit_index <= bit_index;
            end
            if (shift_en) begin
                shift[bit_index] <= rx_sync;
            end else begin
                shift <= shift;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_valid    <= set_valid;
            frame_error <= set_ferr;
            if (set_valid) begin
                rx_data <= shift;
            end else begin
                rx_data <= rx_data;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mismatch flag and its output pulse
    always_ff @(posedge ipClk) begin
        if (ipReset) begin
            par_bad      <= 1'b0;
            parity_error <= 1'b0;
        end else begin
            parity_error <= set_perr;
            if (par_chk) begin
                par_bad <= even_parity(shift) ^ rx_sync;
            end else begin
                par_bad <= par_bad;
            end
        end
    end

    assign opParityError = parity_error;
`endif

    assign opRxData     = rx_data;
    assign opRxValid    = rx_valid;
    assign opFrameError = frame_error;

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CLK_DIV  = 434;
    localparam int HALF_DIV = 217;
    localparam int LAT_EXP  = HALF_DIV + 9 * CLK_DIV + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
    logic       par_flip = 1'b0;
`endif

    uart_rx #(.CLK_DIV(CLK_DIV), .HALF_DIV(HALF_DIV)) dut (
        .ipClk        (clk),
        .ipReset      (reset),
        .ipRx         (rx),
        .opRxData     (rx_data),
        .opRxValid    (rx_valid),
        .opFrameError (frame_error)
`ifdef UART_RX_PARITY_EN
        ,
        .opParityError(parity_error)
`endif
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    // kind: 0 = data valid, 1 = frame error, 2 = parity error
    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    int pulse_cnt = 0;
    int last_pulse_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: every output pulse is matched against the scoreboard
    always @(negedge clk) begin
        logic perr;
        int   kind;
        exp_t e;
`ifdef UART_RX_PARITY_EN
        perr = parity_error;
`else
        perr = 1'b0;
`endif
        if (!reset && (rx_valid || frame_error || perr)) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            chk("pulse_exclusive", 32'(rx_valid) + 32'(frame_error) + 32'(perr), 32'd1);
            kind = frame_error ? 1 : (perr ? 2 : 0);
            if (sbq.size() == 0) begin
                chk("unexpected_pulse", 32'(kind), 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("pulse_kind", 32'(kind), 32'(e.kind));
                chk("pulse_data", 32'(rx_data), 32'(e.data));
            end
        end
    end

    // Drives one frame; called and returns at a falling clock edge
    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CLK_DIV) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        rx = (^d) ^ par_flip;
        repeat (CLK_DIV) @(negedge clk);
`endif
        rx = stop_val;
        repeat (CLK_DIV) @(negedge clk);
    endtask

    task automatic expect_pulse(input int kind, input logic [7:0] d);
        exp_t e;
        e.kind = kind;
        e.data = d;
        sbq.push_back(e);
    endtask

    initial begin
        int start_cyc;
        int lat;
        int saved;

        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_valid", 32'(rx_valid), 32'd0);
        chk("rst_ferr", 32'(frame_error), 32'd0);
        chk("rst_data", 32'(rx_data), 32'h00);
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;
        repeat (10) @(negedge clk);

        // 0x55 with latency measurement
        expect_pulse(0, 8'h55);
        start_cyc = cyc;
        send_frame(8'h55, 1'b1);
        lat = last_pulse_cyc - start_cyc;
        chk("latency_0x55", 32'((lat >= LAT_EXP - 1) && (lat <= LAT_EXP + 1)), 32'd1);
        chk("data_0x55", 32'(rx_data), 32'h55);
        repeat (CLK_DIV) @(negedge clk);

        // back-to-back 0x00, 0xFF
        expect_pulse(0, 8'h00);
        expect_pulse(0, 8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (CLK_DIV) @(negedge clk);
        chk("b2b_queue_empty", 32'(sbq.size()), 32'd0);
        chk("data_0xFF", 32'(rx_data), 32'hFF);

        // 100-cycle glitch on an idle line
        saved = pulse_cnt;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CLK_DIV) @(negedge clk);
        chk("glitch_no_pulse", 32'(pulse_cnt), 32'(saved));
        chk("glitch_state", 32'(dut.state), 32'(IDLE));

        // 0xA3 with stop bit low, break, then 0x3C
        expect_pulse(1, 8'hFF);
        send_frame(8'hA3, 1'b0);
        repeat (2000) @(negedge clk);
        chk("break_state", 32'(dut.state), 32'(WAIT_IDLE));
        chk("ferr_data_held", 32'(rx_data), 32'hFF);
        rx = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
        expect_pulse(0, 8'h3C);
        send_frame(8'h3C, 1'b1);
        chk("data_0x3C", 32'(rx_data), 32'h3C);
        repeat (CLK_DIV) @(negedge clk);

        // 0x81 with reset pulse in the middle of data bit 4
        saved = pulse_cnt;
        rx = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = (i == 0) ? 1'b1 : 1'b0;
            repeat (CLK_DIV) @(negedge clk);
        end
        rx = 1'b0;
        repeat (CLK_DIV / 2) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (CLK_DIV - CLK_DIV / 2 - 5) @(negedge clk);
        rx = 1'b0;
        repeat (2 * CLK_DIV) @(negedge clk);
        rx = 1'b1;
        repeat (CLK_DIV) @(negedge clk);
`ifdef UART_RX_PARITY_EN
        repeat (CLK_DIV) @(negedge clk);
`endif
        repeat (3 * CLK_DIV) @(negedge clk);
        chk("abort_no_pulse", 32'(pulse_cnt), 32'(saved));
        chk("abort_state", 32'(dut.state), 32'(IDLE));
        chk("abort_data_reset", 32'(rx_data), 32'h00);
        expect_pulse(0, 8'h81);
        send_frame(8'h81, 1'b1);
        chk("data_0x81", 32'(rx_data), 32'h81);
        repeat (CLK_DIV) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // good and bad even parity on 0xA5
        expect_pulse(0, 8'hA5);
        par_flip = 1'b0;
        send_frame(8'hA5, 1'b1);
        repeat (CLK_DIV) @(negedge clk);
        expect_pulse(2, 8'hA5);
        par_flip = 1'b1;
        send_frame(8'hA5, 1'b1);
        par_flip = 1'b0;
        repeat (CLK_DIV) @(negedge clk);
        chk("perr_data_held", 32'(rx_data), 32'hA5);
`endif

        repeat (20) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
